// File: rtl/mc_pkg.sv
// Shared types, sizes and the vector clamp for the motion-compensation predictor.
// The optional residual output is enabled by defining MC_RESIDUAL_EN.
package mc_pkg;

    localparam int PIX_W    = 8;
    localparam int AREA_DIM = 8;
    localparam int BLK_DIM  = 4;
    localparam int AREA_PIX = AREA_DIM * AREA_DIM;
    localparam int BLK_PIX  = BLK_DIM * BLK_DIM;
    localparam int SR       = (AREA_DIM - BLK_DIM) / 2;
    localparam int AIDX_W   = $clog2(AREA_PIX);
    localparam int BIDX_W   = $clog2(BLK_PIX);

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic signed [2:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_AREA,
        WAIT_X,
        WAIT_Y,
        OUTPUT
    } state_t;

    localparam vec_t V_MAX = vec_t'(SR);
    localparam vec_t V_MIN = vec_t'(-SR);

    // The 3-bit field can encode 3 and -4/-3, which lie outside the search range.
    function automatic vec_t clamp_vec(input vec_t v);
        if (v > V_MAX) return V_MAX;
        if (v < V_MIN) return V_MIN;
        return v;
    endfunction

endpackage

// File: rtl/mc_pred_if.sv
// Pixel/vector stream bundle of the predictor; MC_RESIDUAL_EN adds the
// current-block input and the residual output.
interface mc_pred_if;
    import mc_pkg::*;

    // Valid-only streams: a beat is consumed on the rising edge where its valid
    // is high and the receiver is in a state that accepts it; there is no ready.
    logic   area_valid;
    pix_t   in_data;
    logic   vec_valid;
    vec_t   in_vector;
    logic   out_valid;
    pix_t   out_data;
    state_t dbg_state;
`ifdef MC_RESIDUAL_EN
    logic                    block_valid;
    logic signed [PIX_W:0]   out_resid;

    modport master (
        output area_valid, in_data, vec_valid, in_vector, block_valid,
        input  out_valid, out_data, dbg_state, out_resid
    );
    modport slave (
        input  area_valid, in_data, vec_valid, in_vector, block_valid,
        output out_valid, out_data, dbg_state, out_resid
    );
`else
    modport master (
        output area_valid, in_data, vec_valid, in_vector,
        input  out_valid, out_data, dbg_state
    );
    modport slave (
        input  area_valid, in_data, vec_valid, in_vector,
        output out_valid, out_data, dbg_state
    );
`endif

endinterface

// File: rtl/mc_area_buf.sv
// 64-entry search-area register file: one synchronous write port and one
// combinational read port.
module mc_area_buf
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [AIDX_W-1:0] wr_idx,
    input  pix_t              wr_data,
    input  logic [AIDX_W-1:0] rd_idx,
    output pix_t              rd_data
);

    // Contents are deliberately left uncleared by reset; a fresh load overwrites them.
    pix_t mem [AREA_PIX];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mc_pred.sv
// Motion-compensation predictor: load an 8x8 area and an (x,y) vector, then
// stream the selected 4x4 block. MC_RESIDUAL_EN adds current-minus-predicted output.
module mc_pred
    import mc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_pred_if.slave  bus
);

    state_t             state, state_next;
    logic [AIDX_W-1:0]  area_cnt;
    logic [BIDX_W-1:0]  out_cnt;
    vec_t               vec_x, vec_y;
    logic               area_we, x_we, y_we, out_step, out_last;
    logic [2:0]         row_base, col_base, row_pix, col_pix;
    logic [AIDX_W-1:0]  rd_idx;
    pix_t               pred_pix;

    always_comb begin
        state_next = state;
        area_we    = 1'b0;
        x_we       = 1'b0;
        y_we       = 1'b0;
        out_step   = 1'b0;
        out_last   = (out_cnt == BIDX_W'(BLK_PIX - 1));
        unique case (state)
            IDLE: begin
                if (bus.area_valid) begin
                    area_we    = 1'b1;
                    state_next = LOAD_AREA;
                end
            end
            LOAD_AREA: begin
                if (bus.area_valid) begin
                    area_we = 1'b1;
                    if (area_cnt == AIDX_W'(AREA_PIX - 1)) state_next = WAIT_X;
                end
            end
            WAIT_X: begin
                if (bus.vec_valid) begin
                    x_we       = 1'b1;
                    state_next = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (bus.vec_valid) begin
                    y_we       = 1'b1;
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                out_step = 1'b1;
                if (out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // area_cnt is 0 in IDLE, so the first pixel lands at index 0 and the
    // count wraps back to 0 after pixel 63.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            area_cnt <= '0;
            out_cnt  <= '0;
            vec_x    <= '0;
            vec_y    <= '0;
        end else begin
            state <= state_next;
            if (area_we)  area_cnt <= area_cnt + 1'b1;
            if (x_we)     vec_x    <= clamp_vec(bus.in_vector);
            if (y_we)     vec_y    <= clamp_vec(bus.in_vector);
            if (out_step) out_cnt  <= out_cnt + 1'b1;
        end
    end

    // y is positive upward, so the block row moves up as y grows.
    assign col_base = 3'(SR) + $unsigned(vec_x);
    assign row_base = 3'(SR) - $unsigned(vec_y);
    assign row_pix  = row_base + {1'b0, out_cnt[3:2]};
    assign col_pix  = col_base + {1'b0, out_cnt[1:0]};
    assign rd_idx   = {row_pix, col_pix};

    mc_area_buf u_area_buf (
        .clk     (clk),
        .we      (area_we),
        .wr_idx  (area_cnt),
        .wr_data (bus.in_data),
        .rd_idx  (rd_idx),
        .rd_data (pred_pix)
    );

    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_data  = bus.out_valid ? pred_pix : '0;
    assign bus.dbg_state = state;

`ifdef MC_RESIDUAL_EN
    pix_t              blk_mem [BLK_PIX];
    logic [BIDX_W-1:0] blk_cnt;
    logic              blk_we;

    assign blk_we = bus.block_valid && (state != OUTPUT);

    always_ff @(posedge clk) begin
        if (rst)                      blk_cnt <= '0;
        else if (out_step && out_last) blk_cnt <= '0;
        else if (blk_we)              blk_cnt <= blk_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (blk_we) blk_mem[blk_cnt] <= bus.in_data;
    end

    assign bus.out_resid = bus.out_valid
        ? ($signed({1'b0, blk_mem[out_cnt]}) - $signed({1'b0, pred_pix}))
        : '0;
`endif

endmodule

// File: doc/mc_pred.md
Name: mc_pred

Overview:
- Motion-compensation predictor: the decode-side counterpart of the motion estimator.
- Captures the same 8x8 search area stream (64 pixels, raster order), then a motion vector as two signed beats (x, then y) in the estimator's output format.
- Emits the 4x4 predicted block selected by that vector as 16 consecutive pixels.
- Sits downstream of the estimator or its bitstream path, feeding reconstruction.

Parameters:
- PIX_W, 8, pixel width in bits.
- AREA_DIM, 8, search-area side in pixels (area holds AREA_DIM*AREA_DIM pixels).
- BLK_DIM, 4, block side in pixels; search range SR = (AREA_DIM-BLK_DIM)/2 = 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- area_valid  in  1  in_data carries one search-area pixel this cycle.
- in_data  in  PIX_W  area pixel, raster order (row 0 col 0 first).
- vec_valid  in  1  in_vector carries one vector beat this cycle.
- in_vector  in  3 signed  first beat is x, second beat is y.
- out_valid  out  1  out_data carries one predicted pixel.
- out_data  out  PIX_W  predicted pixel, raster order within the 4x4 block.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; counters 0; out_valid=0; out_data=0. Area storage is not cleared.
- FSM states: IDLE, LOAD_AREA, WAIT_X, WAIT_Y, OUTPUT.
- IDLE:
  - On area_valid: store the pixel at index 0, area count=1, go to LOAD_AREA.
  - vec_valid is ignored in IDLE.
- LOAD_AREA:
  - Each area_valid cycle stores in_data at the index given by the area count, then increments the count.
  - Gaps (area_valid=0) hold the count.
  - After pixel 63 is stored, go to WAIT_X.
  - vec_valid is ignored during the load.
- WAIT_X: first vec_valid beat latches x, go to WAIT_Y.
- WAIT_Y:
  - Next vec_valid beat latches y, go to OUTPUT.
  - Beats need not be consecutive.
  - area_valid is ignored in WAIT_X and WAIT_Y.
- Vector mapping:
  - Vector components are clamped to [-2,2]: 3 becomes 2, -3 and -4 become -2.
  - Block top-left is col = x+2, row = 2-y, so y is positive upward, matching the estimator.
  - Pixel (r,c) of the block = area[(row+r)*8 + (col+c)].
- OUTPUT:
  - out_valid=1 for exactly 16 consecutive cycles, starting the cycle after the y beat is accepted.
  - Pixels are emitted r-major: (0,0), (0,1), ... (3,3).
  - After the 16th pixel: out_valid=0, go to IDLE.
  - area_valid and vec_valid are ignored during OUTPUT.
- Latency: y-beat edge to first out_valid is 1 cycle; the full block takes 16 cycles.
- out_data=0 whenever out_valid=0.
- Simultaneous area_valid and vec_valid: only the input legal for the current state is consumed.
- rst asserted mid-load or mid-output: abort, next cycle is IDLE with out_valid=0. A partial area is discarded logically; the next load restarts at index 0.
- Back-to-back: an area_valid arriving in the cycle after the 16th output pixel (state IDLE) starts a new load.

Optional Feature:
- MC_RESIDUAL_EN defined:
  - Adds input block_valid (1 bit) and output out_resid (signed PIX_W+1).
  - block_valid beats are accepted only in IDLE, LOAD_AREA, WAIT_X or WAIT_Y. Each beat writes in_data into a 16-entry current-block buffer, indexed by a separate 4-bit counter, raster order.
  - block_valid and area_valid are never asserted in the same cycle.
  - In OUTPUT, out_resid = current pixel minus predicted pixel, valid alongside out_data; out_resid=0 when out_valid=0.
  - Residual for fewer than 16 received pixels is undefined. The block counter resets when OUTPUT ends.
- MC_RESIDUAL_EN undefined: no extra ports or storage.

Decomposition:
- Package mc_pkg:
  - state enum (IDLE, LOAD_AREA, WAIT_X, WAIT_Y, OUTPUT);
  - localparams AREA_PIX=64, BLK_PIX=16, SR=2;
  - pix_t typedef;
  - clamp function for the 3-bit vector.
- Sub-module mc_area_buf: 64xPIX_W register file with write enable plus 6-bit write index, and one combinational 6-bit read index. The FSM and address generation stay in mc_pred.

Test Plan:
- Load area[i]=i, vector (0,0) -> out_data 18,19,20,21,26,27,28,29,34,35,36,37,42,43,44,45; first out_valid exactly 1 cycle after the y beat.
- Same area, vector (2,-2) -> 36..39, 44..47, 52..55, 60..63. Vector (-2,2) -> 0..3, 8..11, 16..19, 24..27.
- Clamp: x=3, y=-4 -> same stream as (2,-2). vec_valid pulsed during LOAD_AREA -> ignored, no output.
- Gapped area_valid (every other cycle) plus vector beats 5 cycles apart -> vector (1,1) yields 11..14, 19..22, 27..30, 35..38.
- rst at output pixel 7 -> out_valid=0 next cycle. A fresh load with area[i]=255-i and vector (0,0) -> first pixel 237.
- MC_RESIDUAL_EN: block pixels all 40, area[i]=i, vector (0,0) -> out_resid 22,21,20,19,14,13,12,11,6,5,4,3,-2,-3,-4,-5.
